// File: rtl/interrupt_sequencer.sv
// Interrupt arbiter and dispatch sequencer: IF/IE/IME flags, EI delay and the
// 5-M-cycle push/jump sequence that steers the CPU into the selected vector.
module interrupt_sequencer #(
    parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        i_Enable,
    input  logic [4:0]  i_Interrupts,
    input  logic [7:0]  i_Data,
    input  logic        i_IF_Write,
    input  logic        i_IE_Write,
    input  logic        i_EI,
    input  logic        i_DI,
    input  logic        i_RETI,
    input  logic        i_Instr_Boundary,
    output logic [7:0]  o_IF,
    output logic [7:0]  o_IE,
    output logic        o_IME,
    output logic        o_Wake,
    output logic        o_Handle_Interrupt,
    output logic        o_Push_High,
    output logic        o_Push_Low,
    output logic        o_Load_PC,
    output logic [15:0] o_Vector
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT1   = 3'd1,
        WAIT2   = 3'd2,
        PUSH_HI = 3'd3,
        PUSH_LO = 3'd4,
        JUMP    = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  if_reg;
    logic [4:0]  if_next;
    logic [7:0]  ie_reg;
    logic [7:0]  ie_next;
    logic        ime;
    logic        ime_next;
    logic        ei_pending;
    logic        ei_pending_next;
    logic        src_valid;
    logic [2:0]  src_idx;
    logic [4:0]  pending;
    logic [4:0]  pending_next;
    logic [4:0]  dispatch_clear;
    logic        wake;
    logic        start;

    function automatic logic [2:0] lowest_index(input logic [4:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign pending = ie_reg[4:0] & if_reg[4:0];
    assign wake    = |pending;
    assign start   = (state == IDLE) && i_Instr_Boundary && ime && wake;

    // Hardware requests dominate; a write replaces the rest, else the dispatch clear applies.
    always_comb begin
        dispatch_clear = 5'b00000;
        if (state == JUMP && src_valid) dispatch_clear = 5'b00001 << src_idx;
        ie_next      = i_IE_Write ? i_Data : ie_reg;
        if_next      = i_Interrupts | (i_IF_Write ? i_Data[4:0] : (if_reg & ~dispatch_clear));
        pending_next = ie_next[4:0] & if_next;
    end

    always_comb begin
        ime_next = ime;
        if (i_DI) begin
            ime_next = 1'b0;
        end else if (start) begin
            ime_next = 1'b0;
        end else if (i_RETI || (ei_pending && i_Instr_Boundary)) begin
            ime_next = 1'b1;
        end

        ei_pending_next = ei_pending;
        if (i_DI) begin
            ei_pending_next = 1'b0;
        end else if (i_EI) begin
            ei_pending_next = 1'b1;
        end else if (i_Instr_Boundary) begin
            ei_pending_next = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state <= IDLE;
        end else if (i_Enable) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? WAIT1 : IDLE;
            WAIT1:   state_next = WAIT2;
            WAIT2:   state_next = PUSH_HI;
            PUSH_HI: state_next = PUSH_LO;
            PUSH_LO: state_next = JUMP;
            JUMP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_Handle_Interrupt = (state != IDLE);
        o_Push_High        = (state == PUSH_HI);
        o_Push_Low         = (state == PUSH_LO);
        o_Load_PC          = (state == JUMP);
        o_Vector           = 16'h0000;
        if (state == JUMP && src_valid) begin
            o_Vector = VECTOR_BASE + {10'd0, src_idx, 3'b000};
        end
    end

    // Source is chosen from the flags as they stand after the high push lands.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            ime        <= 1'b0;
            ei_pending <= 1'b0;
            if_reg     <= 5'd0;
            ie_reg     <= 8'd0;
            src_valid  <= 1'b0;
        end else if (i_Enable) begin
            ime        <= ime_next;
            ei_pending <= ei_pending_next;
            if_reg     <= if_next;
            ie_reg     <= ie_next;
            if (state == PUSH_HI) src_valid <= |pending_next;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Enable && state == PUSH_HI) begin
            src_idx <= lowest_index(pending_next);
        end
    end

    assign o_IF   = {3'b111, if_reg};
    assign o_IE   = ie_reg;
    assign o_IME  = ime;
    assign o_Wake = wake;

endmodule
